pwm_breathe_led: RTL and testbench

- Drives a single LED with a "breathing" PWM pattern.
- A free-running PWM counter compares against a duty value.
- The duty value ramps linearly up from 0 to full scale, then back down to 0, and repeats forever.
- Leaf block with no control inputs: a clock, a reset and one LED output.

---
 rtl/pwm_breathe_led_if.sv | 8 +
 rtl/pwm_breathe_led.sv | 86 ++++++++
 tb/tb_pwm_breathe_led.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pwm_breathe_led_if.sv
// LED output bundle for the breathing PWM driver.
// The driver owns the master side; whatever observes the LED uses the slave side.
interface pwm_breathe_led_if;
  logic led;

  modport master (output led);
  modport slave  (input  led);
endinterface

// File: rtl/pwm_breathe_led.sv
// Breathing LED driver: a free-running PWM counter is compared against a duty
// value that ramps 0 -> MAX -> 0 in a triangle, one step every PERIODS_PER_STEP periods.
module pwm_breathe_led #(
  parameter int WIDTH            = 8,
  parameter int PERIODS_PER_STEP = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  pwm_breathe_led_if.master led_bus
);

  localparam logic [WIDTH-1:0] MAX_DUTY  = {WIDTH{1'b1}};
  localparam int               STEP_W    = (PERIODS_PER_STEP > 1) ? $clog2(PERIODS_PER_STEP) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(PERIODS_PER_STEP - 1);

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_t;

  logic [WIDTH-1:0]  pwm_cnt_r;
  logic [WIDTH-1:0]  duty_r;
  dir_t              dir_r;
  logic [STEP_W-1:0] step_cnt_r;
  logic              led_r;

  logic              period_end_s;
  logic              step_end_s;
  logic [WIDTH-1:0]  duty_up_s;
  logic [WIDTH-1:0]  duty_dn_s;

  // Period/step boundary detection and the two candidate next duty values.
  always_comb begin
    period_end_s = (pwm_cnt_r == MAX_DUTY);
    step_end_s   = (step_cnt_r == STEP_LAST);
    duty_up_s    = duty_r + WIDTH'(1);
    duty_dn_s    = duty_r - WIDTH'(1);
  end

  // PWM counter, registered LED compare and the triangle ramp state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_r  <= '0;
      duty_r     <= '0;
      dir_r      <= DIR_UP;
      step_cnt_r <= '0;
      led_r      <= 1'b0;
    end else begin
      pwm_cnt_r <= pwm_cnt_r + WIDTH'(1);
      led_r     <= (pwm_cnt_r < duty_r);
      if (period_end_s) begin
        if (step_end_s) begin
          step_cnt_r <= '0;
          // Direction flips on the same edge that reaches an extreme, so each extreme lasts one step.
          case (dir_r)
            DIR_UP: begin
              duty_r <= duty_up_s;
              if (duty_up_s == MAX_DUTY) begin
                dir_r <= DIR_DOWN;
              end else begin
                dir_r <= DIR_UP;
              end
            end
            DIR_DOWN: begin
              duty_r <= duty_dn_s;
              if (duty_dn_s == WIDTH'(0)) begin
                dir_r <= DIR_UP;
              end else begin
                dir_r <= DIR_DOWN;
              end
            end
            default: begin
              duty_r <= '0;
              dir_r  <= DIR_UP;
            end
          endcase
        end else begin
          step_cnt_r <= step_cnt_r + STEP_W'(1);
        end
      end
    end
  end

  assign led_bus.led = led_r;

endmodule

// File: tb/tb_pwm_breathe_led.sv
// Scoreboard bench: expected per-period high counts are queued at each reset release
// and a negedge monitor measures each aligned PWM window and compares.
module tb_pwm_breathe_led;

  localparam int WA = 8;
  localparam int PA = 1;
  localparam int WB = 4;
  localparam int PB = 4;
  localparam int NA = 1 << WA;
  localparam int NB = 1 << WB;

  logic clk;
  logic rst_n;

  pwm_breathe_led_if bus_a ();
  pwm_breathe_led_if bus_b ();

  pwm_breathe_led #(.WIDTH(WA), .PERIODS_PER_STEP(PA)) dut_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .led_bus (bus_a)
  );

  pwm_breathe_led #(.WIDTH(WB), .PERIODS_PER_STEP(PB)) dut_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .led_bus (bus_b)
  );

  int checks = 0;
  int fails  = 0;

  int q_a[$];
  int q_b[$];

  int pos[2];
  int hi[2];
  bit dip[2];
  bit gap[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Triangle position from plain arithmetic: step index folded over 2*MAX.
  function automatic int exp_duty(input int w, input int pps, input int p);
    int m;
    int t;
    m = (1 << w) - 1;
    t = (p / pps) % (2 * m);
    return (t <= m) ? t : (2 * m - t);
  endfunction

  task automatic load_expect(input int periods_a, input int periods_b);
    q_a.delete();
    q_b.delete();
    for (int p = 0; p < periods_a; p++) q_a.push_back(exp_duty(WA, PA, p));
    for (int p = 0; p < periods_b; p++) q_b.push_back(exp_duty(WB, PB, p));
  endtask

  task automatic mon_step(input int idx, input logic led_v, input int n);
    int k;
    int e;
    bit have;
    k    = pos[idx] % n;
    have = 1'b0;
    e    = 0;
    if (k == 0) begin
      hi[idx]  = 0;
      dip[idx] = 1'b0;
      gap[idx] = 1'b0;
    end
    if (led_v) begin
      hi[idx]++;
      if (dip[idx]) gap[idx] = 1'b1;
    end else begin
      dip[idx] = 1'b1;
    end
    if (k == n - 1) begin
      if (idx == 0) begin
        if (q_a.size() > 0) begin
          have = 1'b1;
          e    = q_a.pop_front();
        end
      end else begin
        if (q_b.size() > 0) begin
          have = 1'b1;
          e    = q_b.pop_front();
        end
      end
      if (have) begin
        check($sformatf("high_count dut%0d period %0d", idx, pos[idx] / n), hi[idx], e);
        check($sformatf("high_run_contiguous dut%0d period %0d", idx, pos[idx] / n), int'(gap[idx]), 0);
      end
    end
    pos[idx]++;
  endtask

  // Monitor: sample half a cycle after each active edge; window position counts edges since release.
  always @(negedge clk) begin
    if (!rst_n) begin
      pos[0] = 0;
      pos[1] = 0;
    end else begin
      mon_step(0, bus_a.led, NA);
      mon_step(1, bus_b.led, NB);
    end
  end

  initial begin
    bit found;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("led_a_in_reset", int'(bus_a.led), 0);
    check("led_b_in_reset", int'(bus_b.led), 0);

    // Periods 0..257 of the default ramp cover ramp-up and the peak turnaround.
    #2 rst_n = 1'b1;
    load_expect(258, 258 * NA / NB);
    repeat (258 * NA + 2) @(negedge clk);
    check("queue_a_drained_phase1", q_a.size(), 0);
    check("queue_b_drained_phase1", q_b.size(), 0);

    repeat ($urandom_range(0, 300)) @(negedge clk);
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge clk);
      if (bus_a.led) found = 1'b1;
    end
    check("led_a_high_before_async_reset", int'(found), 1);

    #($urandom_range(1, 3));
    rst_n = 1'b0;
    #1;
    check("led_a_async_drop", int'(bus_a.led), 0);
    check("led_b_async_drop", int'(bus_b.led), 0);
    repeat (3) @(negedge clk);
    check("led_a_held_in_reset", int'(bus_a.led), 0);

    // After a mid-ramp reset the triangle restarts at duty 0.
    #2 rst_n = 1'b1;
    load_expect(12, 12 * NA / NB);
    repeat (12 * NA + 4) @(negedge clk);
    check("queue_a_drained_phase2", q_a.size(), 0);
    check("queue_b_drained_phase2", q_b.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
